// File: rtl/lif_neuron_pe.sv
// Leaky integrate-and-fire processing element: saturating membrane integration,
// shift-based leak on each timestep tick, threshold fire with refractory hold-off.
module lif_neuron_pe #(
  parameter int DATA_W       = 16,
  parameter int LEAK_SHIFT   = 0,
  parameter int REFRAC_TICKS = 0,
  parameter int RESET_MODE   = 0,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_spike,
  input  logic                     in_polarity,
  input  logic signed [DATA_W-1:0] in_weight,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic                     tick,
  output logic                     out_spike,
  output logic signed [DATA_W-1:0] membrane,
  output logic                     refractory,
  output logic [CNT_W-1:0]         fire_count
);

  localparam int RC_W = (REFRAC_TICKS > 1) ? $clog2(REFRAC_TICKS + 1) : 1;

  localparam logic [0:0] INTEG  = 1'b0;
  localparam logic [0:0] REFRAC = 1'b1;

  localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  // Clamp a one-bit-wider result back into the DATA_W signed range.
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W:0] x);
    if (x[DATA_W] != x[DATA_W-1])
      return x[DATA_W] ? MIN_V : MAX_V;
    else
      return x[DATA_W-1:0];
  endfunction

  logic [0:0]               state;
  logic [RC_W-1:0]          rc_cnt;
  logic signed [DATA_W-1:0] v;
  logic signed [DATA_W-1:0] acc;
  logic signed [DATA_W-1:0] leaked;
  logic signed [DATA_W-1:0] fire_val;
  logic signed [DATA_W:0]   v_ext;
  logic signed [DATA_W:0]   w_ext;
  logic signed [DATA_W:0]   sum;
  logic signed [DATA_W:0]   diff;
  logic                     fire;

  always_comb begin
    v_ext    = {v[DATA_W-1], v};
    w_ext    = {in_weight[DATA_W-1], in_weight};
    sum      = in_polarity ? (v_ext + w_ext) : (v_ext - w_ext);
    acc      = in_spike ? sat(sum) : v;
    // A shift of zero would leak everything, so zero means no leak at all.
    leaked   = (LEAK_SHIFT == 0) ? acc : (acc - (acc >>> LEAK_SHIFT));
    diff     = {leaked[DATA_W-1], leaked} - {threshold[DATA_W-1], threshold};
    fire_val = (RESET_MODE == 1) ? sat(diff) : '0;
    fire     = (leaked >= threshold);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INTEG;
      rc_cnt     <= '0;
      v          <= '0;
      out_spike  <= 1'b0;
      fire_count <= '0;
    end else begin
      out_spike <= 1'b0;
      if (state == INTEG) begin
        if (!tick) begin
          v <= acc;
        end else if (fire) begin
          out_spike <= 1'b1;
          v         <= fire_val;
          if (fire_count != {CNT_W{1'b1}})
            fire_count <= fire_count + CNT_W'(1);
          if (REFRAC_TICKS > 0) begin
            state  <= REFRAC;
            rc_cnt <= RC_W'(REFRAC_TICKS);
          end
        end else begin
          v <= leaked;
        end
      end else begin
        // The tick that exhausts the counter only ends the hold-off; it never compares.
        if (tick) begin
          rc_cnt <= rc_cnt - RC_W'(1);
          if (rc_cnt == RC_W'(1))
            state <= INTEG;
        end
      end
    end
  end

  assign membrane   = v;
  assign refractory = (state == REFRAC);

endmodule

// File: tb/tb_lif_neuron_pe.sv
// Self-checking bench: several parameterisations share one stimulus stream and are
// compared every cycle against an integer reference model, plus directed spot values.
module tb_lif_neuron_pe;

  localparam int NI = 6;
  localparam int LEAK [NI] = '{0, 0, 2, 0, 0, 0};
  localparam int REFR [NI] = '{0, 0, 0, 2, 2, 0};
  localparam int RM   [NI] = '{0, 1, 0, 0, 1, 0};
  localparam int CW   [NI] = '{16, 16, 16, 16, 16, 2};

  logic clk = 1'b0;
  logic rst, in_spike, in_polarity, tick;
  logic signed [15:0] in_weight, threshold;

  logic        spk_o  [NI];
  logic [15:0] mem_o  [NI];
  logic        refr_o [NI];
  logic [15:0] cnt_o  [NI];
  logic [1:0]  cnt5;

  int checks = 0;
  int failures = 0;

  int mv [NI];
  int mrem [NI];
  int mcnt [NI];
  bit mspk [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI - 1; g++) begin : g_dut
    lif_neuron_pe #(
      .DATA_W(16), .LEAK_SHIFT(LEAK[g]), .REFRAC_TICKS(REFR[g]),
      .RESET_MODE(RM[g]), .CNT_W(16)
    ) dut (
      .clk(clk), .rst(rst), .in_spike(in_spike), .in_polarity(in_polarity),
      .in_weight(in_weight), .threshold(threshold), .tick(tick),
      .out_spike(spk_o[g]), .membrane(mem_o[g]), .refractory(refr_o[g]),
      .fire_count(cnt_o[g])
    );
  end

  lif_neuron_pe #(
    .DATA_W(16), .LEAK_SHIFT(0), .REFRAC_TICKS(0), .RESET_MODE(0), .CNT_W(2)
  ) dut_small_cnt (
    .clk(clk), .rst(rst), .in_spike(in_spike), .in_polarity(in_polarity),
    .in_weight(in_weight), .threshold(threshold), .tick(tick),
    .out_spike(spk_o[5]), .membrane(mem_o[5]), .refractory(refr_o[5]),
    .fire_count(cnt5)
  );
  assign cnt_o[5] = {14'b0, cnt5};

  function automatic int clamp16(int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // Floor division by 2^s, i.e. what an arithmetic right shift means numerically.
  function automatic int floor_div_pow2(int a, int s);
    int d, q;
    d = 1 << s;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  task automatic modelStep();
    int a, l, w, thr;
    w   = int'(in_weight);
    thr = int'(threshold);
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        mv[i] = 0; mspk[i] = 0; mrem[i] = 0; mcnt[i] = 0;
      end else if (mrem[i] > 0) begin
        mspk[i] = 0;
        if (tick) mrem[i] = mrem[i] - 1;
      end else begin
        a = in_spike ? clamp16(in_polarity ? mv[i] + w : mv[i] - w) : mv[i];
        if (!tick) begin
          mv[i] = a; mspk[i] = 0;
        end else begin
          l = (LEAK[i] == 0) ? a : a - floor_div_pow2(a, LEAK[i]);
          if (l >= thr) begin
            mspk[i] = 1;
            mv[i]   = (RM[i] == 1) ? clamp16(l - thr) : 0;
            if (mcnt[i] < (1 << CW[i]) - 1) mcnt[i] = mcnt[i] + 1;
            mrem[i] = REFR[i];
          end else begin
            mv[i] = l; mspk[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input int idx,
                             input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, observed, expected);
      end
  endtask

  function automatic logic [31:0] m16(int x);
    return {16'b0, 16'(x)};
  endfunction

  task automatic checkAll();
    for (int i = 0; i < NI; i++) begin
      checkOutput("out_spike", i, {31'b0, spk_o[i]}, {31'b0, mspk[i]});
      checkOutput("membrane", i, {16'b0, mem_o[i]}, m16(mv[i]));
      checkOutput("refractory", i, {31'b0, refr_o[i]}, {31'b0, (mrem[i] > 0)});
      checkOutput("fire_count", i, {16'b0, cnt_o[i]}, 32'(mcnt[i]));
    end
  endtask

  task automatic applyStimulus(input bit r, input bit sp, input bit pol,
                               input int w, input int thr, input bit tk);
    rst = r; in_spike = sp; in_polarity = pol;
    in_weight = 16'(w); threshold = 16'(thr); tick = tk;
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("reset_mem", 0, {16'b0, mem_o[0]}, 32'h0);
    checkOutput("reset_cnt", 0, {16'b0, cnt_o[0]}, 32'h0);

    // Four +30 spikes then a tick against threshold 100.
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 1, 30, 100, 0);
    applyStimulus(0, 0, 1, 0, 100, 1);
    checkOutput("tp_fire_spk", 0, {31'b0, spk_o[0]}, 32'h1);
    checkOutput("tp_fire_mem", 0, {16'b0, mem_o[0]}, 32'h0);
    checkOutput("tp_fire_cnt", 0, {16'b0, cnt_o[0]}, 32'h1);
    checkOutput("tp_sub_mem", 1, {16'b0, mem_o[1]}, m16(20));
    applyStimulus(0, 0, 1, 0, 100, 0);
    checkOutput("tp_pulse_len", 0, {31'b0, spk_o[0]}, 32'h0);

    // Saturation in both directions.
    applyStimulus(1, 0, 0, 0, 100, 0);
    applyStimulus(0, 1, 1, 16000, 100, 0);
    applyStimulus(0, 1, 1, 16000, 100, 0);
    applyStimulus(0, 1, 1, 1000, 100, 0);
    checkOutput("sat_pos", 0, {16'b0, mem_o[0]}, m16(32767));
    applyStimulus(1, 0, 0, 0, 100, 0);
    applyStimulus(0, 1, 0, 16000, 100, 0);
    applyStimulus(0, 1, 0, 16000, 100, 0);
    applyStimulus(0, 1, 0, 1000, 100, 0);
    checkOutput("sat_neg", 0, {16'b0, mem_o[0]}, m16(-32768));

    // Leak with shift 2.
    applyStimulus(1, 0, 0, 0, 1000, 0);
    applyStimulus(0, 1, 1, 80, 1000, 0);
    applyStimulus(0, 0, 1, 0, 1000, 1);
    checkOutput("leak_60", 2, {16'b0, mem_o[2]}, m16(60));
    applyStimulus(0, 0, 1, 0, 1000, 1);
    checkOutput("leak_45", 2, {16'b0, mem_o[2]}, m16(45));
    applyStimulus(1, 0, 0, 0, 1000, 0);
    applyStimulus(0, 1, 0, 80, 1000, 0);
    applyStimulus(0, 0, 0, 0, 1000, 1);
    checkOutput("leak_neg", 2, {16'b0, mem_o[2]}, m16(-60));
    checkOutput("leak_nospk", 2, {31'b0, spk_o[2]}, 32'h0);

    // Spike and tick in the same cycle.
    applyStimulus(1, 0, 0, 0, 100, 0);
    applyStimulus(0, 1, 1, 90, 100, 0);
    applyStimulus(0, 1, 1, 20, 100, 1);
    checkOutput("same_fire", 0, {31'b0, spk_o[0]}, 32'h1);
    checkOutput("same_mem0", 0, {16'b0, mem_o[0]}, 32'h0);
    applyStimulus(1, 0, 0, 0, 100, 0);
    applyStimulus(0, 1, 1, 90, 100, 0);
    applyStimulus(0, 1, 1, 5, 100, 1);
    checkOutput("same_nofire", 0, {16'b0, mem_o[0]}, m16(95));

    // Refractory period of two ticks.
    applyStimulus(1, 0, 0, 0, 10, 0);
    applyStimulus(0, 1, 1, 50, 10, 1);
    checkOutput("ref_fire", 3, {31'b0, spk_o[3]}, 32'h1);
    applyStimulus(0, 1, 1, 50, 10, 1);
    checkOutput("ref_t1_refr", 3, {31'b0, refr_o[3]}, 32'h1);
    checkOutput("ref_t1_mem", 3, {16'b0, mem_o[3]}, 32'h0);
    checkOutput("ref_t1_spk", 3, {31'b0, spk_o[3]}, 32'h0);
    applyStimulus(0, 1, 1, 50, 10, 1);
    checkOutput("ref_t2_refr", 3, {31'b0, refr_o[3]}, 32'h0);
    checkOutput("ref_t2_spk", 3, {31'b0, spk_o[3]}, 32'h0);
    applyStimulus(0, 1, 1, 50, 10, 1);
    checkOutput("ref_refire", 3, {31'b0, spk_o[3]}, 32'h1);
    checkOutput("ref_cnt2", 3, {16'b0, cnt_o[3]}, 32'h2);

    // Reset aborts a refractory period.
    applyStimulus(1, 0, 0, 0, 10, 0);
    applyStimulus(0, 1, 1, 50, 10, 1);
    checkOutput("abort_v40", 4, {16'b0, mem_o[4]}, m16(40));
    applyStimulus(0, 0, 1, 0, 10, 0);
    applyStimulus(0, 0, 1, 0, 10, 0);
    applyStimulus(1, 0, 1, 0, 10, 0);
    checkOutput("abort_mem", 4, {16'b0, mem_o[4]}, 32'h0);
    checkOutput("abort_refr", 4, {31'b0, refr_o[4]}, 32'h0);
    checkOutput("abort_cnt", 4, {16'b0, cnt_o[4]}, 32'h0);
    applyStimulus(0, 1, 1, 50, 10, 1);
    checkOutput("abort_fire", 4, {31'b0, spk_o[4]}, 32'h1);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      int w, thr;
      w   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                        : int'($urandom_range(0, 250)) - 50;
      thr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                        : int'($urandom_range(0, 600));
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) != 0, w, thr, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
